// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, sequencer state type and opcode classification helpers
// for the ALU requester side (also used by the control unit).
package alu_seq_pkg;

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_SHL    = 5'b00001;
    localparam logic [4:0] OP_SHR    = 5'b00010;
    localparam logic [4:0] OP_SHRA   = 5'b00011;
    localparam logic [4:0] OP_ROL    = 5'b00100;
    localparam logic [4:0] OP_ROR    = 5'b00101;
    localparam logic [4:0] OP_AND    = 5'b00110;
    localparam logic [4:0] OP_OR     = 5'b00111;
    localparam logic [4:0] OP_NOT    = 5'b01000;
    localparam logic [4:0] OP_NEG    = 5'b01001;
    localparam logic [4:0] OP_ADD    = 5'b01010;
    localparam logic [4:0] OP_SUB    = 5'b01011;
    localparam logic [4:0] OP_MUL    = 5'b01100;
    localparam logic [4:0] OP_DIV    = 5'b01101;
    localparam logic [4:0] OP_PASS_A = 5'b10000;

    // Settle counter width covers the legal SETTLE_CYCLES range 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        logic legal;
        case (op)
            OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR,
            OP_AND, OP_OR, OP_NOT, OP_NEG, OP_PASS_A,
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_has_hi(input logic [4:0] op);
        logic has_hi;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: has_hi = 1'b1;
            default:                        has_hi = 1'b0;
        endcase
        return has_hi;
    endfunction

    // ADD/SUB only carry a single carry/borrow bit in the upper word.
    function automatic logic op_hi_is_carry(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, upper-word validity, carry-only upper
// word and architectural HI/LO double-write class (MUL/DIV).
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] op_i,
    output logic       legal_o,
    output logic       has_hi_o,
    output logic       hi_is_carry_o,
    output logic       is_hilo_write_o
);

    always_comb begin
        legal_o         = is_legal_op(op_i);
        has_hi_o        = op_has_hi(op_i);
        hi_is_carry_o   = op_hi_is_carry(op_i);
        is_hilo_write_o = (op_i == OP_MUL) || (op_i == OP_DIV);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Requester-side ALU sequencer: accepts one request, holds ALU inputs for a settle
// window, captures Z and returns a typed response. Optional HI/LO registers: ALU_SEQ_HILO_REGS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = 32
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_opcode,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [4:0]          alu_opcode,
    input  logic [2*DATA_W-1:0] alu_z,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_lo,
    output logic [DATA_W-1:0]   resp_hi,
    output logic                resp_hi_valid,
    output logic                resp_err,
    output logic [DATA_W-1:0]   hi_q,
    output logic [DATA_W-1:0]   lo_q,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and once raised holds its payload stable.

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cls_legal_q, cls_has_hi_q, cls_carry_q;
    logic              dec_legal, dec_has_hi, dec_carry, dec_hilo;
    logic              accept, resp_fire;
    logic [DATA_W-1:0] z_hi_masked;

    alu_op_decode u_decode (
        .op_i           (req_opcode),
        .legal_o        (dec_legal),
        .has_hi_o       (dec_has_hi),
        .hi_is_carry_o  (dec_carry),
        .is_hilo_write_o(dec_hilo)
    );

    assign accept    = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SETTLE;
            SETTLE:  if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        dbg_state = state_q;
    end

    // Upper word is never forwarded for single-word ops; ADD/SUB keep only the carry bit.
    always_comb begin
        z_hi_masked = '0;
        if (cls_has_hi_q) begin
            if (cls_carry_q) begin
                z_hi_masked = {{(DATA_W-1){1'b0}}, alu_z[DATA_W]};
            end else begin
                z_hi_masked = alu_z[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= OP_NOP;
            cnt_q         <= '0;
            cls_legal_q   <= 1'b0;
            cls_has_hi_q  <= 1'b0;
            cls_carry_q   <= 1'b0;
            resp_valid    <= 1'b0;
            resp_lo       <= '0;
            resp_hi       <= '0;
            resp_hi_valid <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cls_legal_q  <= dec_legal;
                        cls_has_hi_q <= dec_has_hi;
                        cls_carry_q  <= dec_carry;
                        // Illegal ops leave the ALU idle and just spend one cycle in SETTLE.
                        if (dec_legal) begin
                            alu_a      <= req_a;
                            alu_b      <= req_b;
                            alu_opcode <= req_opcode;
                            cnt_q      <= CNT_W'(SETTLE_CYCLES);
                        end else begin
                            cnt_q      <= CNT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        resp_valid <= 1'b1;
                        if (cls_legal_q) begin
                            resp_lo       <= alu_z[DATA_W-1:0];
                            resp_hi       <= z_hi_masked;
                            resp_hi_valid <= cls_has_hi_q;
                            resp_err      <= 1'b0;
                        end else begin
                            resp_lo       <= '0;
                            resp_hi       <= '0;
                            resp_hi_valid <= 1'b0;
                            resp_err      <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        resp_valid <= 1'b0;
                        alu_opcode <= OP_NOP;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_HILO_REGS_EN
    logic cls_hilo_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cls_hilo_q <= 1'b0;
        end else if (accept) begin
            cls_hilo_q <= dec_hilo;
        end
    end

    // Architectural HI/LO commit on the response handshake; errors never commit.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == RESP && resp_fire && cls_legal_q) begin
            lo_q <= resp_lo;
            if (cls_hilo_q) begin
                hi_q <= resp_hi;
            end
        end
    end
`else
    logic hilo_unused;

    assign hilo_unused = dec_hilo;
    assign hi_q        = '0;
    assign lo_q        = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU drives alu_z, a request-level
// reference model predicts each response, checked in order via an expected queue.
module tb_alu_op_sequencer;

    localparam int DW = 32;
    localparam int S  = 2;
    localparam int RW = 2*DW + 2;

    logic            clock = 1'b0;
    logic            clear_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [4:0]      req_opcode = 5'd0;
    logic [DW-1:0]   req_a = '0;
    logic [DW-1:0]   req_b = '0;
    logic [DW-1:0]   alu_a, alu_b;
    logic [4:0]      alu_opcode;
    logic [2*DW-1:0] alu_z;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_lo, resp_hi;
    logic            resp_hi_valid, resp_err;
    logic [DW-1:0]   hi_q, lo_q;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_resp;
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.SETTLE_CYCLES(S), .DATA_W(DW)) dut (
        .clock(clock), .clear_n(clear_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_z(alu_z),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_hi_valid(resp_hi_valid),
        .resp_err(resp_err), .hi_q(hi_q), .lo_q(lo_q), .dbg_state(dbg_state)
    );

    // Behavioural ALU; the upper word carries junk wherever it is architecturally undefined.
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] junk;
        logic [32:0] s;
        logic signed [63:0] sa, sb, q, r;
        junk = a ^ ~b ^ 32'hC3C3_0F0F;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            5'd1:  return {junk, a << b[4:0]};
            5'd2:  return {junk, a >> b[4:0]};
            5'd3:  return {junk, 32'($signed(a) >>> b[4:0])};
            5'd4:  return {junk, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
            5'd5:  return {junk, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
            5'd6:  return {junk, a & b};
            5'd7:  return {junk, a | b};
            5'd8:  return {junk, ~a};
            5'd9:  return {junk, -a};
            5'd16: return {junk, a};
            5'd10: begin s = {1'b0, a} + {1'b0, b}; return {junk[30:0], s}; end
            5'd11: begin s = {1'b0, a} - {1'b0, b}; return {junk[30:0], s}; end
            5'd12: return 64'(sa * sb);
            5'd13: begin
                if (b == 32'd0) return {junk, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {junk, ~junk};
        endcase
    endfunction

    assign alu_z = alu_model(alu_opcode, alu_a, alu_b);

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                          5'd10, 5'd11, 5'd12, 5'd13, 5'd16};
    endfunction

    // Reference response packed as {err, hi_valid, hi, lo}.
    function automatic logic [RW-1:0] ref_resp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] z;
        if (!is_legal(op)) return {1'b1, 1'b0, 64'b0};
        z = alu_model(op, a, b);
        if (op == 5'd10 || op == 5'd11) return {2'b01, 31'b0, z[32], z[31:0]};
        if (op == 5'd12 || op == 5'd13) return {2'b01, z};
        return {2'b00, 32'b0, z[31:0]};
    endfunction

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [RW-1:0] e, got, snap;
        logic [68:0]   alu_snap;
        logic          legal;
        int            lat, exp_lat;
        e = ref_resp(op, a, b);
        exp_q.push_back(e);
        legal   = is_legal(op);
        exp_lat = legal ? S : 1;

        @(negedge clock);
        req_opcode = op; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clock); #1;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (req_ready !== 1'b0 || alu_opcode !== (legal ? op : 5'd0) ||
                (legal && (alu_a !== a || alu_b !== b))) begin
                errors++;
                $display("FAIL settle_hold: ready=%b op=%h a=%h b=%h want ready=0 op=%h a=%h b=%h",
                         req_ready, alu_opcode, alu_a, alu_b, legal ? op : 5'd0, a, b);
            end
            // Request-side noise while busy must be ignored.
            req_valid = 1'($urandom); req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL latency op=%h: got %0d want %0d cycles", op, lat, exp_lat);
        end

        snap     = {resp_err, resp_hi_valid, resp_hi, resp_lo};
        alu_snap = {alu_a, alu_b, alu_opcode};
        req_valid = 1'b1; req_opcode = 5'd10; req_a = $urandom; req_b = $urandom;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                {resp_err, resp_hi_valid, resp_hi, resp_lo} !== snap ||
                {alu_a, alu_b, alu_opcode} !== alu_snap) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid=%b ready=%b resp=%h want valid=1 ready=0 resp=%h",
                         i, resp_valid, req_ready, {resp_err, resp_hi_valid, resp_hi, resp_lo}, snap);
            end
        end

        resp_ready = 1'b1;
        got = {resp_err, resp_hi_valid, resp_hi, resp_lo};
        e = exp_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL resp op=%h a=%h b=%h: valid=%b got %h want %h", op, a, b, resp_valid, got, e);
        end
        last_resp = got;
        @(posedge clock); #1;
        resp_ready = 1'b0; req_valid = 1'b0;
`ifdef ALU_SEQ_HILO_REGS_EN
        if (legal) begin
            m_lo = e[31:0];
            if (op == 5'd12 || op == 5'd13) m_hi = e[63:32];
        end
`endif
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || alu_opcode !== 5'd0) begin
            errors++;
            $display("FAIL handshake: valid=%b ready=%b alu_op=%h want 0 1 00", resp_valid, req_ready, alu_opcode);
        end
        checks++;
        if (hi_q !== m_hi || lo_q !== m_lo) begin
            errors++; $display("FAIL hilo: got hi=%h lo=%h want hi=%h lo=%h", hi_q, lo_q, m_hi, m_lo);
        end
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_opcode !== 5'd0 || alu_a !== '0 ||
            alu_b !== '0 || resp_lo !== '0 || resp_hi !== '0 || resp_hi_valid !== 1'b0 ||
            resp_err !== 1'b0 || hi_q !== '0 || lo_q !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b op=%h lo=%h hi=%h err=%b hq=%h lq=%h",
                     req_ready, resp_valid, alu_opcode, resp_lo, resp_hi, resp_err, hi_q, lo_q);
        end
        @(negedge clock); @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_directed;
        do_op(5'd10, 32'd7, 32'd5, 0);
        checks++;
        if (last_resp !== {2'b01, 32'd0, 32'd12}) begin
            errors++; $display("FAIL add_7_5: got %h want lo=12 hi=0 hv=1", last_resp);
        end
        do_op(5'd12, 32'hFFFF_FFFF, 32'd3, 1);
        checks++;
        if (last_resp !== {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++; $display("FAIL mul_m1_3: got %h want lo=FFFFFFFD hi=FFFFFFFF", last_resp);
        end
`ifdef ALU_SEQ_HILO_REGS_EN
        checks++;
        if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL mul_hilo: got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi_q, lo_q);
        end
`endif
        do_op(5'd13, 32'd17, 32'd5, 0);
        checks++;
        if (last_resp !== {2'b01, 32'd2, 32'd3}) begin
            errors++; $display("FAIL div_17_5: got %h want lo=3 hi=2", last_resp);
        end
        do_op(5'd6, 32'hF0, 32'h3C, 0);
        checks++;
        if (last_resp !== {2'b00, 32'd0, 32'h30}) begin
            errors++; $display("FAIL and_f0_3c: got %h want lo=30 hi=0 hv=0", last_resp);
        end
`ifdef ALU_SEQ_HILO_REGS_EN
        checks++;
        if (hi_q !== 32'd2 || lo_q !== 32'h30) begin
            errors++; $display("FAIL and_hilo: got hi=%h lo=%h want 2 30", hi_q, lo_q);
        end
`endif
    endtask

    task automatic test_illegal;
        do_op(5'd0, $urandom, $urandom, 0);
        checks++;
        if (last_resp !== {1'b1, 1'b0, 64'b0}) begin
            errors++; $display("FAIL illegal_00: got %h want err only", last_resp);
        end
        do_op(5'd31, $urandom, $urandom, 2);
        checks++;
        if (last_resp !== {1'b1, 1'b0, 64'b0}) begin
            errors++; $display("FAIL illegal_1f: got %h want err only", last_resp);
        end
    endtask

    task automatic test_backpressure;
        do_op(5'd11, 32'd3, 32'd9, 5);
        do_op(5'd4, 32'h8000_0001, 32'd1, 5);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) do_op(5'd7 + 5'(i), $urandom, $urandom, 0);
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        @(negedge clock);
        req_opcode = 5'd12; req_a = 32'h1234_5678; req_b = 32'h9; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (alu_opcode !== 5'd12 || req_ready !== 1'b0) begin
            errors++; $display("FAIL abort_started: op=%h ready=%b want 0c 0", alu_opcode, req_ready);
        end
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || alu_opcode !== 5'd0 || resp_valid !== 1'b0 ||
            resp_lo !== '0 || resp_hi !== '0 || resp_hi_valid !== 1'b0 || resp_err !== 1'b0 ||
            hi_q !== '0 || lo_q !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: a=%h op=%h valid=%b lo=%h hq=%h lq=%h ready=%b want all 0, ready 1",
                     alu_a, alu_opcode, resp_valid, resp_lo, hi_q, lo_q, req_ready);
        end
        m_hi = '0; m_lo = '0;
        @(negedge clock); @(negedge clock);
        clear_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_resp: got resp_valid=1 want 0");
        end
        do_op(5'd10, 32'hFFFF_FFFF, 32'd1, 1);
    endtask

    task automatic test_random;
        logic [4:0] legal_ops[14] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                      5'd10, 5'd11, 5'd12, 5'd13, 5'd16};
        logic [4:0] op;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 13)];
            else op = 5'($urandom);
            do_op(op, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
